// File: rtl/water_cycle_sequencer_if.sv
// Control/status bundle between the water cycle sequencer and its environment.
// Optional feature macro: WATER_FAULT_RETRY_EN (adds retry_active).
interface water_cycle_sequencer_if;
    logic       start;
    logic       abort;
    logic       clear_fault;
    logic [9:0] water_level;
    logic       error_flag;
    logic       inlet_valve;
    logic       drain_pump;
    logic       mode;
    logic       mon_reset;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] state;
`ifdef WATER_FAULT_RETRY_EN
    logic       retry_active;
`endif

    modport master (
        input  start, abort, clear_fault, water_level, error_flag,
        output inlet_valve, drain_pump, mode, mon_reset, busy, done, fault, state
`ifdef WATER_FAULT_RETRY_EN
        , output retry_active
`endif
    );

    modport slave (
        output start, abort, clear_fault, water_level, error_flag,
        input  inlet_valve, drain_pump, mode, mon_reset, busy, done, fault, state
`ifdef WATER_FAULT_RETRY_EN
        , input retry_active
`endif
    );
endinterface

// File: rtl/water_cycle_sequencer.sv
// Fill/wash/drain phase controller feeding the water flow monitor's mode and re-baseline pulse.
// Optional feature macro: WATER_FAULT_RETRY_EN (one 16-cycle retry before a sticky fault).
module water_cycle_sequencer #(
    parameter int unsigned FILL_LEVEL  = 600,
    parameter int unsigned DRAIN_LEVEL = 50,
    parameter int unsigned WASH_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    water_cycle_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WASH  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;
`ifdef WATER_FAULT_RETRY_EN
    localparam logic [2:0]  S_RETRY    = 3'd6;
    localparam logic [31:0] RETRY_LAST = 32'd15;
`endif

    localparam logic [9:0]  FILL_LVL  = 10'(FILL_LEVEL);
    localparam logic [9:0]  DRAIN_LVL = 10'(DRAIN_LEVEL);
    localparam logic [31:0] WASH_LAST = 32'(WASH_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        inlet_q, inlet_d;
    logic        pump_q, pump_d;
    logic        mode_q, mode_d;
    logic        mon_reset_q, mon_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        err_ok;
    logic [2:0]  err_dest;
`ifdef WATER_FAULT_RETRY_EN
    logic        retry_used_q, retry_used_d;
    logic [2:0]  resume_q, resume_d;
    logic        retry_q, retry_d;
`endif

    // The monitor re-baselines while mon_reset is high, so its error flag is meaningless then.
    assign err_ok = bus.error_flag && !mon_reset_q;

    always_comb begin
        state_d = state_q;
`ifdef WATER_FAULT_RETRY_EN
        retry_used_d = retry_used_q;
        resume_d     = resume_q;
        err_dest     = retry_used_q ? S_FAULT : S_RETRY;
`else
        err_dest     = S_FAULT;
`endif

        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_FILL;
            S_FILL: begin
                if (bus.abort)                         state_d = S_DRAIN;
                else if (bus.water_level >= FILL_LVL)  state_d = S_WASH;
                else if (err_ok)                       state_d = err_dest;
            end
            S_WASH:  if (bus.abort || cnt_q == WASH_LAST) state_d = S_DRAIN;
            S_DRAIN: begin
                if (bus.water_level <= DRAIN_LVL)      state_d = S_DONE;
                else if (err_ok)                       state_d = err_dest;
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: if (bus.clear_fault) state_d = S_IDLE;
`ifdef WATER_FAULT_RETRY_EN
            S_RETRY: if (cnt_q == RETRY_LAST) state_d = resume_q;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef WATER_FAULT_RETRY_EN
        if (state_q == S_IDLE) retry_used_d = 1'b0;
        if (state_d == S_RETRY && state_q != S_RETRY) begin
            retry_used_d = 1'b1;
            resume_d     = state_q;
        end
`endif

        // Shared dwell counter: restarts on every state change, only runs in timed states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_WASH
`ifdef WATER_FAULT_RETRY_EN
                     || state_q == S_RETRY
`endif
                    ) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs decode the next state so they are valid in a state's first cycle.
        inlet_d     = (state_d == S_FILL);
        pump_d      = (state_d == S_DRAIN);
        mode_d      = (state_d == S_FILL) || (state_d == S_WASH);
        busy_d      = (state_d == S_FILL) || (state_d == S_WASH) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        fault_d     = (state_d == S_FAULT);
        mon_reset_d = ((state_d == S_FILL) || (state_d == S_DRAIN)) && (state_d != state_q);
`ifdef WATER_FAULT_RETRY_EN
        retry_d     = (state_d == S_RETRY);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            inlet_q     <= 1'b0;
            pump_q      <= 1'b0;
            mode_q      <= 1'b0;
            mon_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
`ifdef WATER_FAULT_RETRY_EN
            retry_used_q <= 1'b0;
            resume_q     <= S_IDLE;
            retry_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inlet_q     <= inlet_d;
            pump_q      <= pump_d;
            mode_q      <= mode_d;
            mon_reset_q <= mon_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
`ifdef WATER_FAULT_RETRY_EN
            retry_used_q <= retry_used_d;
            resume_q     <= resume_d;
            retry_q      <= retry_d;
`endif
        end
    end

    assign bus.inlet_valve = inlet_q;
    assign bus.drain_pump  = pump_q;
    assign bus.mode        = mode_q;
    assign bus.mon_reset   = mon_reset_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
    assign bus.state       = state_q;
`ifdef WATER_FAULT_RETRY_EN
    assign bus.retry_active = retry_q;
`endif

endmodule

// File: doc/water_cycle_sequencer.md
Name: water_cycle_sequencer

Overview:
- Fill/wash/drain phase controller sitting directly upstream of the water flow monitor.
- Drives the monitor's mode input and a one-cycle monitor re-baseline pulse.
- Consumes the monitor's error_flag to abort into a sticky fault.
- Drives the inlet valve and drain pump from the 10-bit water level sensor and a programmable wash duration.

Parameters:
- FILL_LEVEL, 600, sensor code at or above which filling completes (must exceed DRAIN_LEVEL).
- DRAIN_LEVEL, 50, sensor code at or below which draining completes.
- WASH_CYCLES, 1000, clock cycles spent in WASH (1 to 2^32-1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a cycle; sampled only in IDLE.
- abort  input  1  skip to drain; honoured in FILL and WASH.
- clear_fault  input  1  leave FAULT.
- water_level  input  10  water level sensor code, unsigned.
- error_flag  input  1  flow error from monitor.
- inlet_valve  output  1  open inlet.
- drain_pump  output  1  run drain pump.
- mode  output  1  to monitor: 1 fill, 0 drain.
- mon_reset  output  1  active-high monitor reset pulse.
- busy  output  1  state is FILL, WASH or DRAIN.
- done  output  1  one-cycle completion pulse.
- fault  output  1  sticky fault indicator.
- state  output  3  current state code, debug.

Behaviour:
- Single clk domain. All outputs are registered and decoded from the next state, so they are valid in the first cycle of each state.
- reset_n low forces IDLE immediately and clears all outputs to 0 (state=0), including mid-phase. mode resets to 0.
- State codes: IDLE=0, FILL=1, WASH=2, DRAIN=3, DONE=4, FAULT=5. Codes 6 and 7 return to IDLE on the next edge.
- IDLE:
  - All outputs 0.
  - start=1 → FILL.
- FILL:
  - inlet_valve=1, mode=1, busy=1.
  - mon_reset=1 in the first FILL cycle only.
  - Transition priority: abort → DRAIN; else water_level>=FILL_LEVEL → WASH; else error_flag=1 with mon_reset=0 → FAULT.
  - error_flag is ignored while mon_reset=1.
- WASH:
  - All actuators off, mode=1, busy=1. error_flag ignored.
  - 32-bit counter cleared on entry and incremented each WASH cycle.
  - Exits to DRAIN in the cycle the counter reaches WASH_CYCLES-1, so WASH lasts exactly WASH_CYCLES cycles.
  - abort → DRAIN immediately.
- DRAIN:
  - drain_pump=1, mode=0, busy=1.
  - mon_reset=1 in the first DRAIN cycle only.
  - water_level<=DRAIN_LEVEL → DONE; else error_flag=1 with mon_reset=0 → FAULT.
  - abort has no effect.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start in DONE is ignored.
- FAULT:
  - fault=1, inlet_valve=0, drain_pump=0, mode=0, busy=0.
  - clear_fault=1 → IDLE. start is ignored in that same cycle and while in FAULT.
- Simultaneous events:
  - Level threshold and error_flag in the same cycle: threshold wins.
  - abort and threshold in FILL: abort wins.
- Level comparisons are unsigned 10-bit.
- inlet_valve and drain_pump are never both 1.

Optional Feature:
- Macro: WATER_FAULT_RETRY_EN.
- Defined:
  - First qualifying error_flag in FILL or DRAIN goes to RETRY (code 6) instead of FAULT.
  - RETRY holds all actuators off for 16 cycles, then re-enters the interrupted phase with a fresh mon_reset pulse.
  - A second error in the same start-initiated cycle → FAULT.
  - The retry-used flag clears in IDLE.
  - Output retry_active (1 bit) is 1 in RETRY.
- Undefined:
  - No RETRY state, no retry_active port.
  - Code 6 is illegal and recovers to IDLE.

Test Plan (FILL_LEVEL=600, DRAIN_LEVEL=50, WASH_CYCLES=8):
- Nominal: start pulse, water_level ramps 0→600 then holds, later ramps to 50 → FILL (state=1, mon_reset one cycle) → WASH exactly 8 cycles → DRAIN (mon_reset one cycle) → done=1 one cycle → IDLE; valve and pump never both high.
- Fill fault: in FILL, hold water_level=100 and assert error_flag from cycle 3 → state=5, fault=1, actuators 0. start ignored; clear_fault → IDLE next cycle.
- Masking: error_flag=1 during the mon_reset cycle of FILL and throughout WASH → no fault; same cycle water_level=600 and error_flag=1 in FILL → WASH.
- Abort: abort in WASH cycle 4 → DRAIN next edge with mon_reset=1; abort in DRAIN → no change.
- Async reset: reset_n low mid-DRAIN, between clock edges → drain_pump=0, state=0 immediately; after release, start restarts in FILL.
- WATER_FAULT_RETRY_EN: first error in DRAIN → RETRY 16 cycles, then DRAIN with mon_reset; second error → FAULT.
